// File: rtl/dsp_mac_sequencer.sv
// Control sequencer for one multiply/post-add DSP slice (A/B reg -> M reg -> P reg).
// Accepts N operand beats over a valid/ready stream and drives the slice clock
// enables and OPMODE so that P ends up holding sum(A*B). DONE pulses once P is final.
module dsp_mac_sequencer #(
    parameter int          LEN_WIDTH    = 8,
    parameter logic [7:0]  OPMODE_FIRST = 8'b00000001,
    parameter logic [7:0]  OPMODE_MAC   = 8'b00001001
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] LEN,
    input  logic                 ABORT,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic                 BUSY,
    output logic                 DSP_CEAB,
    output logic                 DSP_CEM,
    output logic                 DSP_CEP,
    output logic                 DSP_RSTP,
    output logic [7:0]           DSP_OPMODE,
    output logic                 DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FEED  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam logic [LEN_WIDTH-1:0] CNT_ZERO = LEN_WIDTH'(0);
    localparam logic [LEN_WIDTH-1:0] CNT_ONE  = LEN_WIDTH'(1);

    state_t                 state_r, state_nxt_s;
    logic [LEN_WIDTH-1:0]   cnt_r, cnt_nxt_s;
    logic                   first_pend_r, first_pend_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   v1_r, f1_r, l1_r;
    logic                   v2_r, f2_r, l2_r;
    logic                   ready_s, accept_s, last_s;

    // Handshake: ABORT outranks everything, so no beat is taken in an abort cycle.
    always_comb begin
        ready_s  = 1'b0;
        accept_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == ST_FEED && !ABORT) begin
            ready_s  = 1'b1;
            accept_s = IN_VALID;
            last_s   = IN_VALID && (cnt_r == CNT_ONE);
        end else begin
            ready_s  = 1'b0;
        end
    end

    // Next-state, terms-remaining count, first-term marker and DONE generation.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        first_pend_nxt_s = first_pend_r;
        done_nxt_s       = 1'b0;
        if (ABORT) begin
            state_nxt_s      = ST_IDLE;
            cnt_nxt_s        = CNT_ZERO;
            first_pend_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START && (LEN != CNT_ZERO)) begin
                        state_nxt_s      = ST_FEED;
                        cnt_nxt_s        = LEN;
                        first_pend_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FEED: begin
                    if (accept_s) begin
                        cnt_nxt_s        = cnt_r - CNT_ONE;
                        first_pend_nxt_s = 1'b0;
                        if (last_s) begin
                            state_nxt_s = ST_DRAIN;
                        end else begin
                            state_nxt_s = ST_FEED;
                        end
                    end else begin
                        state_nxt_s = ST_FEED;
                    end
                end
                ST_DRAIN: begin
                    // The last term is on its P edge: the sum is final after this cycle.
                    if (v2_r && l2_r) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s      = ST_IDLE;
                    cnt_nxt_s        = CNT_ZERO;
                    first_pend_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and pipeline-flag registers; flags mirror the slice M and P stages.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            first_pend_r <= 1'b0;
            done_r       <= 1'b0;
            v1_r <= 1'b0; f1_r <= 1'b0; l1_r <= 1'b0;
            v2_r <= 1'b0; f2_r <= 1'b0; l2_r <= 1'b0;
        end else if (ABORT) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            first_pend_r <= 1'b0;
            done_r       <= 1'b0;
            v1_r <= 1'b0; f1_r <= 1'b0; l1_r <= 1'b0;
            v2_r <= 1'b0; f2_r <= 1'b0; l2_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            first_pend_r <= first_pend_nxt_s;
            done_r       <= done_nxt_s;
            v1_r <= accept_s;
            f1_r <= accept_s & first_pend_r;
            l1_r <= last_s;
            v2_r <= v1_r;
            f2_r <= f1_r;
            l2_r <= l1_r;
        end
    end

    // Output decode: enables follow the flag pipeline, P reset only on abort.
    always_comb begin
        IN_READY   = ready_s;
        BUSY       = (state_r != ST_IDLE);
        DSP_CEAB   = accept_s;
        DSP_CEM    = v1_r;
        DSP_CEP    = v2_r;
        DSP_RSTP   = ABORT;
        DONE       = done_r;
        DSP_OPMODE = OPMODE_MAC;
        if (v2_r && f2_r) begin
            DSP_OPMODE = OPMODE_FIRST;
        end else begin
            DSP_OPMODE = OPMODE_MAC;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer: randomized operand/valid stimulus,
// a timing-level reference model of the job, and a behavioural slice to check P.
module tb_dsp_mac_sequencer;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       START = 1'b0;
    logic [7:0] LEN = 8'd0;
    logic       ABORT = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY, BUSY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE;
    logic [7:0] DSP_OPMODE;

    logic [7:0]  a_in = 8'd0, b_in = 8'd0;
    logic [7:0]  a_reg, b_reg;
    logic [31:0] m_reg, p_reg;

    int vectors = 0;
    int errors  = 0;

    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_MAC   = 8'h09;

    dsp_mac_sequencer dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .LEN(LEN), .ABORT(ABORT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .BUSY(BUSY),
        .DSP_CEAB(DSP_CEAB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
        .DSP_RSTP(DSP_RSTP), .DSP_OPMODE(DSP_OPMODE), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Behavioural slice driven by the sequencer outputs.
    always @(posedge CLK) begin
        if (DSP_CEAB) begin
            a_reg <= a_in;
            b_reg <= b_in;
        end
        if (DSP_CEM) m_reg <= 32'(a_reg) * 32'(b_reg);
        if (DSP_RSTP) p_reg <= 32'd0;
        else if (DSP_CEP) p_reg <= (DSP_OPMODE == OP_FIRST) ? m_reg : p_reg + m_reg;
    end

    task automatic test_reset();
        RSTN = 1'b0;
        #12;
        vectors++;
        if ({IN_READY, BUSY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {IN_READY, BUSY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE});
        end
        vectors++;
        if (DSP_OPMODE !== OP_MAC) begin
            errors++; $display("FAIL reset_opmode got %h exp %h", DSP_OPMODE, OP_MAC);
        end
        @(negedge CLK); RSTN = 1'b1;
        @(negedge CLK);
        vectors++;
        if (IN_READY !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got rdy=%b busy=%b exp 0 0", IN_READY, BUSY);
        end
    endtask

    // One job: mode 0 valid always high, 1 random valid, 2 valid from pat (cycles 1..8).
    task automatic run_job(input int n, input int mode, input logic [7:0] pat, input bit start_in_feed);
        bit      acc_a [0:599];
        int      acc_cnt, first_c, last_c;
        logic [31:0] sum;
        bit      vld, exp_rdy, exp_acc, exp_cem, exp_cep, exp_done, exp_busy, done_seen;
        logic [7:0] exp_op;
        for (int i = 0; i < 600; i++) acc_a[i] = 1'b0;
        acc_cnt = 0; first_c = -10; last_c = -10; sum = 32'd0; done_seen = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1; LEN = 8'(n); IN_VALID = 1'b0; ABORT = 1'b0;
        @(negedge CLK);
        vectors++;
        if (BUSY !== 1'b0 || IN_READY !== 1'b0) begin
            errors++; $display("FAIL job_idle n=%0d got busy=%b rdy=%b exp 0 0", n, BUSY, IN_READY);
        end
        for (int c = 1; c < 600 && !done_seen; c++) begin
            @(posedge CLK); #1;
            START = start_in_feed && (c == 2);
            LEN   = 8'($urandom_range(1, 255));
            if (mode == 0)      vld = 1'b1;
            else if (mode == 1) vld = 1'($urandom_range(0, 1));
            else                vld = (c <= 8) ? pat[c-1] : 1'b1;
            IN_VALID = vld;
            a_in = 8'($urandom); b_in = 8'($urandom);
            exp_rdy = (acc_cnt < n);
            exp_acc = exp_rdy && vld;
            acc_a[c] = exp_acc;
            if (exp_acc) begin
                if (acc_cnt == 0) first_c = c;
                acc_cnt++;
                sum = sum + 32'(a_in) * 32'(b_in);
                if (acc_cnt == n) last_c = c;
            end
            @(negedge CLK);
            exp_cem  = acc_a[c-1];
            exp_cep  = (c >= 2) ? acc_a[c-2] : 1'b0;
            exp_op   = (c - 2 == first_c) ? OP_FIRST : OP_MAC;
            exp_done = (last_c > 0) && (c == last_c + 3);
            exp_busy = !exp_done;
            vectors++;
            if (IN_READY !== exp_rdy || DSP_CEAB !== exp_acc) begin
                errors++;
                $display("FAIL feed n=%0d c=%0d got rdy=%b ceab=%b exp %b %b", n, c, IN_READY, DSP_CEAB, exp_rdy, exp_acc);
            end
            vectors++;
            if (DSP_CEM !== exp_cem || DSP_CEP !== exp_cep) begin
                errors++;
                $display("FAIL pipe n=%0d c=%0d got cem=%b cep=%b exp %b %b", n, c, DSP_CEM, DSP_CEP, exp_cem, exp_cep);
            end
            vectors++;
            if (DSP_OPMODE !== exp_op) begin
                errors++; $display("FAIL opmode n=%0d c=%0d got %h exp %h", n, c, DSP_OPMODE, exp_op);
            end
            vectors++;
            if (DONE !== exp_done || BUSY !== exp_busy || DSP_RSTP !== 1'b0) begin
                errors++;
                $display("FAIL status n=%0d c=%0d got done=%b busy=%b rstp=%b exp %b %b 0",
                         n, c, DONE, BUSY, DSP_RSTP, exp_done, exp_busy);
            end
            if (exp_done) begin
                done_seen = 1'b1;
                vectors++;
                if (p_reg !== sum) begin
                    errors++; $display("FAIL sum n=%0d got %0d exp %0d", n, p_reg, sum);
                end
            end
        end
        IN_VALID = 1'b0; START = 1'b0;
        if (!done_seen) begin
            vectors++; errors++;
            $display("FAIL job_timeout n=%0d got no completion exp DONE", n);
        end
    endtask

    task automatic test_len_zero();
        @(posedge CLK); #1;
        START = 1'b1; LEN = 8'd0; IN_VALID = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            vectors++;
            if ({BUSY, IN_READY, DSP_CEAB, DSP_CEM, DSP_CEP, DONE} !== 6'b0) begin
                errors++;
                $display("FAIL len_zero c=%0d got %b exp 000000", c, {BUSY, IN_READY, DSP_CEAB, DSP_CEM, DSP_CEP, DONE});
            end
            @(posedge CLK); #1; START = 1'b0;
        end
        IN_VALID = 1'b0;
    endtask

    task automatic test_abort();
        @(posedge CLK); #1;
        START = 1'b1; LEN = 8'd5; IN_VALID = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge CLK); #1; START = 1'b0; IN_VALID = 1'b1;
            a_in = 8'($urandom); b_in = 8'($urandom);
        end
        @(posedge CLK); #1; ABORT = 1'b1;
        @(negedge CLK);
        vectors++;
        if (DSP_RSTP !== 1'b1 || DONE !== 1'b0 || DSP_CEAB !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle got rstp=%b done=%b ceab=%b busy=%b exp 1 0 0 1", DSP_RSTP, DONE, DSP_CEAB, BUSY);
        end
        @(posedge CLK); #1; ABORT = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({BUSY, IN_READY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE} !== 7'b0 || p_reg !== 32'd0) begin
            errors++;
            $display("FAIL abort_idle got %b p=%0d exp 0000000 p=0",
                     {BUSY, IN_READY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE}, p_reg);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            vectors++;
            if (DONE !== 1'b0 || DSP_CEP !== 1'b0) begin
                errors++; $display("FAIL abort_nodone c=%0d got done=%b cep=%b exp 0 0", c, DONE, DSP_CEP);
            end
        end
        IN_VALID = 1'b0;
        run_job(2, 0, 8'h00, 1'b0);
    endtask

    task automatic test_abort_start_idle();
        @(posedge CLK); #1;
        START = 1'b1; LEN = 8'd5; ABORT = 1'b1; IN_VALID = 1'b1;
        @(negedge CLK);
        vectors++;
        if (DSP_RSTP !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL abort_start got rstp=%b busy=%b exp 1 0", DSP_RSTP, BUSY);
        end
        @(posedge CLK); #1; START = 1'b0; ABORT = 1'b0;
        @(negedge CLK);
        vectors++;
        if (BUSY !== 1'b0 || IN_READY !== 1'b0 || DSP_RSTP !== 1'b0) begin
            errors++; $display("FAIL abort_start_drop got busy=%b rdy=%b rstp=%b exp 0 0 0", BUSY, IN_READY, DSP_RSTP);
        end
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        @(posedge CLK); #1;
        START = 1'b1; LEN = 8'd3; IN_VALID = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            START = (c == 2); LEN = 8'd7; IN_VALID = 1'b1;
        end
        START = 1'b0;
        vectors++;
        if (BUSY !== 1'b1 || IN_READY !== 1'b0 || DSP_CEP !== 1'b1) begin
            errors++; $display("FAIL drain_state got busy=%b rdy=%b cep=%b exp 1 0 1", BUSY, IN_READY, DSP_CEP);
        end
        #2 RSTN = 1'b0;
        #1;
        vectors++;
        if ({BUSY, IN_READY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE} !== 7'b0 || DSP_OPMODE !== OP_MAC) begin
            errors++;
            $display("FAIL reset_mid_drain got %b op=%h exp 0000000 op=09",
                     {BUSY, IN_READY, DSP_CEAB, DSP_CEM, DSP_CEP, DSP_RSTP, DONE}, DSP_OPMODE);
        end
        @(negedge CLK); RSTN = 1'b1; IN_VALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            vectors++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b0) begin
                errors++; $display("FAIL post_drain_reset c=%0d got done=%b busy=%b rdy=%b exp 0 0 0", c, DONE, BUSY, IN_READY);
            end
        end
    endtask

    initial begin
        test_reset();
        run_job(4, 0, 8'h00, 1'b0);
        run_job(3, 2, 8'b00011001, 1'b0);
        run_job(1, 0, 8'h00, 1'b0);
        test_len_zero();
        for (int j = 0; j < 6; j++) run_job($urandom_range(1, 20), 1, 8'h00, 1'b1);
        run_job(255, 0, 8'h00, 1'b0);
        test_abort();
        test_abort_start_idle();
        test_reset_mid_drain();
        run_job(2, 1, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
